// File: rtl/rtmc_pkg.sv
// Shared opcodes, status codes and state encoding
// for the RTMC byte-stream register bridge.
package rtmc_pkg;

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_TMO   = 8'hEE;
  localparam logic [7:0] ST_BADOP = 8'hFF;

  typedef enum logic [2:0] {
    OP,
    ADDR,
    WHI,
    WLO,
    BUS,
    RSTAT,
    RHI,
    RLO
  } state_t;

  function automatic logic is_op(
    input logic [7:0] b
  );
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/rtmc_bus_init.sv
// Register-bus initiator: one strobe per start,
// dropped on ack or after TIMEOUT_CYC strobe cycles.
module rtmc_bus_init
  import rtmc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_wr,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdat,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic              done,
  output logic              timed_out,
  output logic [DATA_W-1:0] rdat
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic              r_wr;
  logic              r_rd;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rdat;
  logic              w_strb;
  logic              w_last;

  assign w_strb    = r_wr | r_rd;
  assign w_last    = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign done      = w_strb & reg_ack;
  assign timed_out = w_strb & ~reg_ack & w_last;

  assign reg_wr = r_wr;
  assign reg_rd = r_rd;
  assign rdat   = r_rdat;

  // strobe drops on the ack edge so the responder sees one request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
      r_rdat <= '0;
    end else if (start) begin
      r_wr  <= is_wr;
      r_rd  <= ~is_wr;
      r_cnt <= '0;
    end else if (done | timed_out) begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (r_rd && reg_ack) r_rdat <= reg_rdat;
    end else if (w_strb) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rtmc_bridge.sv
// Byte-stream command bridge onto the register bus.
// RTMC_BRIDGE_FRAME_TIMEOUT_EN: abandon idle partial frames.
module rtmc_bridge
  import rtmc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_drop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdat,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdat,
  input  logic              reg_ack,
  output logic              busy
);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdat;
  logic [7:0]        r_status;
  logic              r_drop;
  logic              w_start;
  logic              w_done;
  logic              w_tmo;
  logic              w_frame_to;
  logic [DATA_W-1:0] w_rdat;

  assign reg_addr = r_addr;
  assign reg_wdat = r_wdat;
  assign rx_drop  = r_drop;
  assign busy     = (r_state != OP);

  rtmc_bus_init #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .is_wr     (r_is_wr),
    .reg_ack   (reg_ack),
    .reg_rdat  (reg_rdat),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .done      (w_done),
    .timed_out (w_tmo),
    .rdat      (w_rdat)
  );

`ifdef RTMC_BRIDGE_FRAME_TIMEOUT_EN
  logic [15:0] r_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (rx_valid ||
                 !(r_state inside {ADDR, WHI, WLO})) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 16'd1;
    end
  end

  assign w_frame_to = (r_idle == 16'hFFFF);
`else
  assign w_frame_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OP;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    unique case (r_state)
      OP: begin
        if (rx_valid)
          w_nxt = is_op(rx_data) ? ADDR : RSTAT;
      end
      ADDR: begin
        if (rx_valid) begin
          w_nxt   = r_is_wr ? WHI : BUS;
          w_start = ~r_is_wr;
        end else if (w_frame_to) begin
          w_nxt = OP;
        end
      end
      WHI: begin
        if (rx_valid)        w_nxt = WLO;
        else if (w_frame_to) w_nxt = OP;
      end
      WLO: begin
        if (rx_valid) begin
          w_nxt   = BUS;
          w_start = 1'b1;
        end else if (w_frame_to) begin
          w_nxt = OP;
        end
      end
      BUS: begin
        if (w_done | w_tmo) w_nxt = RSTAT;
      end
      RSTAT: begin
        if (tx_ready)
          w_nxt = (r_status == ST_OK && !r_is_wr)
                ? RHI : OP;
      end
      RHI: begin
        if (tx_ready) w_nxt = RLO;
      end
      RLO: begin
        if (tx_ready) w_nxt = OP;
      end
      default: w_nxt = OP;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (1'b1)
      (r_state == RSTAT): begin
        tx_valid = 1'b1;
        tx_data  = r_status;
      end
      (r_state == RHI): begin
        tx_valid = 1'b1;
        tx_data  = w_rdat[15:8];
      end
      (r_state == RLO): begin
        tx_valid = 1'b1;
        tx_data  = w_rdat[7:0];
      end
      default: ;
    endcase
  end

  // bytes landing outside frame collection are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_status <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= rx_valid &
        (r_state inside {BUS, RSTAT, RHI, RLO});
      case (r_state)
        OP: begin
          if (rx_valid) begin
            if (is_op(rx_data))
              r_is_wr <= (rx_data == OP_WR);
            else
              r_status <= ST_BADOP;
          end
        end
        ADDR: if (rx_valid) r_addr <= rx_data;
        WHI:  if (rx_valid) r_wdat[15:8] <= rx_data;
        WLO:  if (rx_valid) r_wdat[7:0] <= rx_data;
        BUS: begin
          if (w_done)     r_status <= ST_OK;
          else if (w_tmo) r_status <= ST_TMO;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtmc_bridge.sv
// Scoreboard bench for rtmc_bridge: queued tx bytes
// and bus cycles checked by independent monitors.
module tb_rtmc_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_drop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdat;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdat;
  logic        reg_ack;
  logic        busy;

  always #5 clk = ~clk;

  rtmc_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_drop  (rx_drop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .reg_addr (reg_addr),
    .reg_wdat (reg_wdat),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdat (reg_rdat),
    .reg_ack  (reg_ack),
    .busy     (busy)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdat;
    int          width;
  } bus_t;

  logic [7:0] tx_q[$];
  bus_t       bus_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_drop = 0;

  int          ack_dly  = 0;
  bit          ack_en   = 1'b1;
  bit          stall_en = 1'b0;
  logic [15:0] rdat_val = 16'h0;
  int          hi_cnt   = 0;

  assign reg_ack  = ack_en && (reg_wr || reg_rd)
                  && (hi_cnt == ack_dly);
  assign reg_rdat = rdat_val;

  always @(posedge clk)
    hi_cnt <= (reg_wr || reg_rd) ? hi_cnt + 1 : 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // tx_ready generator: 5 low cycles per byte when stalling
  initial begin
    int st_cnt;
    st_cnt   = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && tx_valid) begin
        if (st_cnt == 5) begin
          tx_ready = 1'b1;
          st_cnt   = 0;
        end else begin
          tx_ready = 1'b0;
          st_cnt++;
        end
      end else begin
        tx_ready = !stall_en;
        st_cnt   = 0;
      end
    end
  end

  // tx monitor
  logic       pv_v = 1'b0;
  logic       pv_r = 1'b0;
  logic [7:0] pv_d = 8'h0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (pv_v && !pv_r && rst_n) begin
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, pv_d);
    end
    if (tx_valid && tx_ready) begin
      chk("tx_byte_expected", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) begin
        e = tx_q.pop_front();
        chk("tx_byte", tx_data, e);
      end
    end
    pv_v = tx_valid;
    pv_r = tx_ready;
    pv_d = tx_data;
  end

  // bus monitor
  logic pv_s = 1'b0;
  int   width = 0;
  bus_t cur = '{1'b0, 8'h0, 16'h0, 0};
  always @(negedge clk) begin
    logic s;
    s = reg_wr | reg_rd;
    if (s && !pv_s) begin
      chk("bus_expected", bus_q.size() != 0, 1);
      if (bus_q.size() != 0) begin
        cur = bus_q.pop_front();
        chk("bus_dir", reg_wr, cur.wr);
        chk("bus_addr", reg_addr, cur.addr);
        if (cur.wr) chk("bus_wdat", reg_wdat, cur.wdat);
      end
      width = 1;
    end else if (s) begin
      width++;
      chk("bus_addr_stable", reg_addr, cur.addr);
    end else if (pv_s && cur.width != 0) begin
      chk("bus_width", width, cur.width);
    end
    if (s) chk("bus_excl", reg_wr & reg_rd, 0);
    pv_s = s;
  end

  always @(negedge clk)
    if (rx_drop) n_drop++;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_bus(input logic wr,
                          input logic [7:0] a,
                          input logic [15:0] d,
                          input int w);
    bus_t t;
    t.wr = wr;
    t.addr = a;
    t.wdat = d;
    t.width = w;
    bus_q.push_back(t);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(busy == 1'b0 && tx_q.size() == 0 &&
                 bus_q.size() == 0 && !reg_wr &&
                 !reg_rd) && k < 3000);
    chk({nm, "_done"}, k < 3000, 1);
  endtask

  task automatic rst_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_tx_valid"}, tx_valid, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_reg_wr"}, reg_wr, 0);
    chk({nm, "_reg_rd"}, reg_rd, 0);
    chk({nm, "_reg_addr"}, reg_addr, 0);
    chk({nm, "_reg_wdat"}, reg_wdat, 0);
    chk({nm, "_rx_drop"}, rx_drop, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_outputs("reset");
    rst_n = 1'b1;

    // write 57 02 00 55
    push_bus(1'b1, 8'h02, 16'h0055, 1);
    tx_q.push_back(8'h00);
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h55);
    wait_idle("write");

    // read 52 00 -> 0142
    rdat_val = 16'h0142;
    push_bus(1'b0, 8'h00, 16'h0, 1);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h42);
    send_byte(8'h52);
    send_byte(8'h00);
    wait_idle("read");

    // bad opcode then a normal read
    tx_q.push_back(8'hFF);
    send_byte(8'h41);
    wait_idle("badop");
    rdat_val = 16'hBEEF;
    push_bus(1'b0, 8'h01, 16'h0, 1);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    send_byte(8'h52);
    send_byte(8'h01);
    wait_idle("after_badop");

    // bus timeout
    ack_en = 1'b0;
    push_bus(1'b0, 8'h07, 16'h0, 255);
    tx_q.push_back(8'hEE);
    send_byte(8'h52);
    send_byte(8'h07);
    wait_idle("timeout");
    ack_en = 1'b1;

    // stalled transmitter
    stall_en = 1'b1;
    rdat_val = 16'hA55A;
    push_bus(1'b0, 8'h10, 16'h0, 1);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h5A);
    send_byte(8'h52);
    send_byte(8'h10);
    wait_idle("stall");
    stall_en = 1'b0;

    // byte injected during BUS
    ack_dly = 3;
    push_bus(1'b1, 8'h03, 16'h1234, 4);
    tx_q.push_back(8'h00);
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h99);
    wait_idle("drop");
    chk("rx_drop_count", n_drop, 1);
    ack_dly = 0;
    rdat_val = 16'h1234;
    push_bus(1'b0, 8'h03, 16'h0, 1);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    send_byte(8'h52);
    send_byte(8'h03);
    wait_idle("after_drop");

    // reset while reg_wr is high
    ack_en = 1'b0;
    push_bus(1'b1, 8'h05, 16'hABCD, 0);
    send_byte(8'h57);
    send_byte(8'h05);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_wr", reg_wr, 1);
    rst_n = 1'b0;
    #1;
    rst_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ack_en = 1'b1;
    rdat_val = 16'h0142;
    push_bus(1'b0, 8'h00, 16'h0, 1);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h42);
    send_byte(8'h52);
    send_byte(8'h00);
    wait_idle("after_rst");

    repeat (4) @(negedge clk);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("rx_drop_total", n_drop, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rtmc_bridge.md
Name: rtmc_bridge

Overview:
Byte-stream command bridge that initiates transactions on the motor-controller register bus (reg_addr/reg_wdat/reg_wr/reg_rd/reg_rdat/reg_ack). It sits between a UART byte receiver/transmitter pair and the register responder. It parses command frames from the RX byte stream, runs one bus cycle per frame, and returns a status/data response on the TX byte stream.

Parameters:
- ADDR_W, 8, register bus address width; must be 8, so one frame byte carries the address.
- DATA_W, 16, register bus data width; must be 16, so two frame bytes carry data, MSB first.
- TIMEOUT_CYC, 255, cycles to wait for reg_ack before abandoning a bus cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe; rx_data valid
- rx_drop  out  1  single-cycle pulse; byte arrived while bridge not accepting
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- reg_addr  out  ADDR_W  bus address
- reg_wdat  out  DATA_W  bus write data
- reg_wr  out  1  write request, level
- reg_rd  out  1  read request, level
- reg_rdat  in  DATA_W  read data; valid in the cycle reg_ack=1
- reg_ack  in  1  responder acknowledge
- busy  out  1  high in any state other than OP

Behaviour:
- Reset values: all outputs 0. FSM is in OP.
- Frames:
  - Write: 0x57 ('W'), addr, wdat[15:8], wdat[7:0].
  - Read: 0x52 ('R'), addr.
- Responses: status byte, then wdat-order bytes for a successful read only.
  - Status 0x00: OK.
  - Status 0xEE: bus timeout.
  - Status 0xFF: bad opcode.
- FSM states: OP, ADDR, WHI, WLO, BUS, RSTAT, RHI, RLO.
  - OP, rx_valid: byte 0x57 or 0x52 latches the op and goes to ADDR. Any other byte latches status 0xFF and goes to RSTAT.
  - ADDR, rx_valid: latch reg_addr. Write goes to WHI; read goes to BUS.
  - WHI, rx_valid: latch reg_wdat[15:8] and go to WLO.
  - WLO, rx_valid: latch reg_wdat[7:0] and go to BUS.
  - BUS entry: reg_wr or reg_rd is registered high on the cycle after the final frame byte.
  - BUS, reg_ack sampled 1: drop the strobe on that same edge, capture reg_rdat if reading, set status 0x00, go to RSTAT. Holding the strobe longer would make the responder toggle ack.
  - BUS timeout: cycle counter counts the cycles the strobe is high. When it reaches TIMEOUT_CYC without ack, drop the strobe, set status 0xEE, go to RSTAT.
  - RSTAT: present status on tx_data with tx_valid=1.
    - On handshake with status 0x00 and a read: go to RHI.
    - Otherwise: go to OP.
  - RHI: present rdat[15:8]; on handshake go to RLO.
  - RLO: present rdat[7:0]; on handshake go to OP.
- TX hold rule: while tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid deasserts the cycle after the last handshake.
- RX is not back-pressured. An rx_valid in BUS, RSTAT, RHI or RLO discards the byte and pulses rx_drop for 1 cycle.
- Latency from final frame byte to strobe: 1 cycle.
- reg_wr and reg_rd are never high together. reg_addr and reg_wdat are stable whenever a strobe is high.
- Reset mid-frame or mid-bus: strobes drop immediately (async) and the FSM returns to OP. The partial frame is lost.

Optional Feature:
RTMC_BRIDGE_FRAME_TIMEOUT_EN
- Defined:
  - An inter-byte counter runs in ADDR, WHI and WLO, reset on each rx_valid.
  - After 2^16 idle cycles the partial frame is abandoned and the FSM returns to OP silently, with no response and no bus cycle.
- Undefined: the counter is absent, and a partial frame waits indefinitely.

Decomposition:
- Package rtmc_pkg holds:
  - OP_WR=8'h57, OP_RD=8'h52;
  - ST_OK=8'h00, ST_TMO=8'hEE, ST_BADOP=8'hFF;
  - the bridge state enum.
- One sub-module, rtmc_bus_init, owns the strobe/ack/timeout handshake.
  - Inputs: start, is_wr.
  - Outputs: done, timed_out, captured rdat.

Test Plan:
- Write frame 57 02 00 55, responder acks 1 cycle after strobe:
  - reg_wr high for exactly 1 cycle with reg_addr=0x02 and reg_wdat=0x0055;
  - tx emits 0x00; busy returns to 0.
- Read frame 52 00, responder returns 0x0142: tx emits 00, 01, 42 in order; reg_rd high for 1 cycle.
- Bad opcode 0x41:
  - tx emits 0xFF; no strobe;
  - the next frame 52 01 processes normally.
- Read with reg_ack tied 0:
  - reg_rd high exactly 255 cycles, then drops;
  - tx emits 0xEE only.
- Read response with tx_ready low for 5 cycles per byte: tx_data and tx_valid stay stable; bytes are 00, hi, lo with none repeated or lost.
- Byte injected during BUS gives one rx_drop pulse and no frame corruption.
- rst_n asserted while reg_wr is high: all outputs 0 immediately; after release, frame 52 00 succeeds.
